cnx_queue_ctrl: RTL and testbench
=================================

CNX_QUEUE_CTRL -- requirements
Module: cnx_queue_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, power of two ≥2: number of byte slots in the capture queue.
REQ-002 Parameter BUSY_HOLD, default 4, ≥1: clk cycles busy is held after each accepted strobe.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 strobe  input  1  asynchronous Centronics strobe from the printer port.
REQ-006 centronix  input  8  Centronics data bus; valid while strobe is at its active level.
REQ-007 inv_strobe  input  1  0: strobe active-low, falling edge captures; 1: strobe active-high, rising edge captures.
REQ-008 inv_busy  input  1  0: busy driven high when not ready; 1: polarity inverted.
REQ-009 busy  output  1  Centronics busy line to the host, polarity per inv_busy.
REQ-010 rd_req  input  1  one-cycle pulse from the SPI side requesting a pop.
REQ-011 rd_data  output  8  popped byte; valid when rd_valid=1.
REQ-012 rd_valid  output  1  one-cycle pulse, one cycle after an accepted rd_req.
REQ-013 level  output  $clog2(DEPTH)+1  current queue occupancy, 0..DEPTH.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 ovf_clr  input  1  clears ovf on the next clk edge.

Function
REQ-016 strobe shall pass through a 2-flop synchronizer, then XOR with inv_strobe; a capture event is a 0->1 transition of that signal, detected with a third flop.
REQ-017 centronix shall be registered on the same clk edge as the first synchronizer stage; the byte written is the one sampled two cycles before the detected edge.
REQ-018 Capture event with level<DEPTH: write the byte at wr_ptr, increment wr_ptr modulo DEPTH, increment level.
REQ-019 Capture event with level==DEPTH: discard the byte, set ovf, leave pointers and level unchanged.
REQ-020 rd_req with level>0: present mem[rd_ptr] on rd_data, pulse rd_valid next cycle, increment rd_ptr modulo DEPTH, decrement level.
REQ-021 rd_req with level==0: no pop, rd_valid stays 0, rd_data holds its last value.
REQ-022 Capture and pop in the same cycle with 0<level<DEPTH: both take effect, level unchanged.
REQ-023 Same cycle, level==DEPTH: pop succeeds and the capture is written; level stays DEPTH, ovf not set.
REQ-024 Same cycle, level==0: the capture is written, the pop is refused, level becomes 1.
REQ-025 Busy FSM states: IDLE, HOLD, FULL.
REQ-026 IDLE -> HOLD on a capture event: load the hold counter with BUSY_HOLD-1.
REQ-027 HOLD: decrement the counter each cycle; at 0 go to FULL if level==DEPTH, else IDLE; a capture event in HOLD reloads the counter.
REQ-028 Any state -> FULL whenever level==DEPTH after the update; FULL -> IDLE on the first cycle level<DEPTH.
REQ-029 Internal not_ready = (state!=IDLE); busy = not_ready XOR inv_busy, registered, so busy changes one cycle after the state.
REQ-030 A change of inv_busy shall take effect on busy within one cycle.
REQ-031 A change of inv_strobe while strobe is stable may create a false capture event; this is permitted, and software changes polarity only while the queue is idle.
REQ-032 ovf_clr coincident with an overflow event: set wins, ovf=1.

Reset
REQ-033 rst=1 shall immediately force:
 - wr_ptr=rd_ptr=level=0, ovf=0, rd_valid=0, rd_data=8'h00
 - FSM=IDLE, hold counter=0
 - synchronizer flops=0, busy=inv_busy
REQ-034 Queue contents shall not be reset; they are unreadable until rewritten.
REQ-035 Deassertion of rst shall not generate a capture event, even when strobe is at its active level.

Verification
REQ-036 inv_strobe=0, inv_busy=0; three low pulses with data 8'h41, 8'h42, 8'h43 -> level=3; busy high for BUSY_HOLD cycles after each capture, delayed 4 cycles from the strobe fall; three rd_req pulses -> rd_data 41,42,43, then level=0.
REQ-037 DEPTH=8; nine captures, no reads -> level=8, busy stays high (FULL), ovf=1, 9th byte lost; one rd_req -> busy low after the FSM leaves FULL; ovf_clr -> ovf=0.
REQ-038 level=0; rd_req -> rd_valid stays 0, level=0, rd_data unchanged.
REQ-039 level=8; capture and rd_req in the same cycle -> level=8, ovf=0, oldest byte returned, new byte at tail.
REQ-040 rst asserted mid-HOLD with level=5 and strobe held active; rst released -> level=0, busy=inv_busy, no capture until the next strobe edge.
REQ-041 inv_strobe=1, inv_busy=1; rising-edge strobe with data 8'hA5 -> byte captured, busy goes low during HOLD, then returns high.

Source files
------------

// File: rtl/cnx_queue_ctrl.sv
// Centronics capture queue: synchronizes the printer strobe, queues captured bytes
// for the SPI side to pop, and drives the busy handshake back to the host.
module cnx_queue_ctrl #(
    parameter int DEPTH     = 8,
    parameter int BUSY_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   strobe,
    input  logic [7:0]             centronix,
    input  logic                   inv_strobe,
    input  logic                   inv_busy,
    output logic                   busy,
    input  logic                   rd_req,
    output logic [7:0]             rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   ovf_clr
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (BUSY_HOLD > 1) ? $clog2(BUSY_HOLD) : 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(BUSY_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    logic          sync1_q, sync2_q, det_q;
    logic [2:0]    fill_q;
    logic [7:0]    cdat_p0_q, cdat_p1_q;
    logic          strb_act, capture;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          pop_ok, wr_ok, ovf_set, is_full;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nr_q;

    // Stage 0/1: strobe synchronizer with the data bus delayed alongside it.
    // fill_q keeps the edge detector quiet until all three flops hold real samples,
    // so leaving reset with strobe already active never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            det_q   <= 1'b0;
            fill_q  <= 3'b000;
        end else begin
            sync1_q <= strobe;
            sync2_q <= sync1_q;
            det_q   <= strb_act;
            fill_q  <= {fill_q[1:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        cdat_p0_q <= centronix;
        cdat_p1_q <= cdat_p0_q;
    end

    assign strb_act = ~(sync2_q ^ inv_strobe);
    assign capture  = fill_q[2] & strb_act & ~det_q;

    // Stage 2: queue update
    assign is_full = (level_q == FULL_LVL);
    assign pop_ok  = rd_req && (level_q != '0);
    assign wr_ok   = capture && (!is_full || pop_ok);
    assign ovf_set = capture && is_full && !pop_ok;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        ovf_d      = ovf_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem[rd_ptr_q];
        end
        if (wr_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !wr_ok) begin
            level_d = level_q - 1'b1;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= cdat_p1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Busy FSM; a full queue overrides whatever the hold timer would do.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (capture) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FULL: begin
                if (level_d != FULL_LVL) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (level_d == FULL_LVL) begin
            state_d = ST_FULL;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            nr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nr_q    <= (state_q != ST_IDLE);
        end
    end

    // Polarity applied after the register so an inv_busy change shows up at once.
    assign busy     = nr_q ^ inv_busy;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_cnx_queue_ctrl.sv
// Bench for cnx_queue_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model.
module tb_cnx_queue_ctrl;
    localparam int DEPTH = 8;
    localparam int BH    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strobe = 1'b1;
    logic [7:0] centronix = 8'h00;
    logic       inv_strobe = 1'b0;
    logic       inv_busy = 1'b0;
    logic       rd_req = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       busy, rd_valid, ovf;
    logic [7:0] rd_data;
    logic [3:0] level;

    always #5 clk = ~clk;

    cnx_queue_ctrl #(.DEPTH(DEPTH), .BUSY_HOLD(BH)) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .centronix(centronix),
        .inv_strobe(inv_strobe), .inv_busy(inv_busy), .busy(busy),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: byte queue, sticky flag, and the busy rules in terms of
    // "cycles of hold remaining" and "queue full".
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0, m_rvld = 1'b0, m_nr = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    bit         m_full = 1'b0;
    int         m_hold = 0;
    int         since = 0;
    logic       h_s[4], h_i[4];
    logic [7:0] h_d[4];
    bit         m_cap, m_pop, m_set;

    function automatic logic act(input logic s, input logic inv);
        return inv ? s : ~s;
    endfunction

    always @(posedge clk) begin
        for (int i = 3; i > 0; i--) begin
            h_s[i] = h_s[i-1];
            h_i[i] = h_i[i-1];
            h_d[i] = h_d[i-1];
        end
        h_s[0] = strobe;
        h_i[0] = inv_strobe;
        h_d[0] = centronix;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_rvld = 1'b0; m_rdata = 8'h00;
            m_full = 1'b0; m_hold = 0; m_nr = 1'b0; since = 0;
        end else begin
            if (since < 8) since++;
            // strobe seen two cycles late through the synchronizer, edge vs. the cycle before
            m_cap = (since >= 4) && (act(h_s[2], h_i[0]) == 1'b1) && (act(h_s[3], h_i[1]) == 1'b0);
            m_pop = rd_req && (mq.size() > 0);
            m_nr  = m_full || (m_hold > 0);
            m_rvld = m_pop;
            if (m_pop) m_rdata = mq.pop_front();
            m_set = 1'b0;
            if (m_cap) begin
                if (mq.size() < DEPTH) mq.push_back(h_d[2]);
                else m_set = 1'b1;
            end
            if (m_set) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (mq.size() == DEPTH) begin
                m_full = 1'b1; m_hold = 0;
            end else if (m_full) begin
                m_full = 1'b0; m_hold = 0;
            end else if (m_cap) begin
                m_hold = BH;
            end else if (m_hold > 0) begin
                m_hold--;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_level", level, 0);
            check_eq("rst_ovf", ovf, 0);
            check_eq("rst_rd_valid", rd_valid, 0);
            check_eq("rst_rd_data", rd_data, 0);
            check_eq("rst_busy", busy, inv_busy);
        end else begin
            check_eq("level", level, mq.size());
            check_eq("ovf", ovf, m_ovf);
            check_eq("rd_valid", rd_valid, m_rvld);
            check_eq("rd_data", rd_data, m_rdata);
            check_eq("busy", busy, m_nr ^ inv_busy);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_misc(input int rd_pct, input int clr_pct);
        rd_req  = (int'($urandom_range(99)) < rd_pct);
        ovf_clr = (int'($urandom_range(99)) < clr_pct);
    endtask

    task automatic pulse(input logic [7:0] d, input int act_len, input int gap,
                         input int rd_pct, input int clr_pct);
        centronix = d;
        strobe    = inv_strobe;
        repeat (act_len) begin
            drive_misc(rd_pct, clr_pct);
            tick(1);
        end
        strobe = ~inv_strobe;
        repeat (gap) begin
            centronix = 8'($urandom);
            drive_misc(rd_pct, clr_pct);
            tick(1);
        end
        rd_req  = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic pop1();
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (mq.size() > 0 && guard < 64) begin
            pop1();
            tick(1);
            guard++;
        end
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(5);

        // three bytes in, three bytes out
        pulse(8'h41, 2, 6, 0, 0);
        pulse(8'h42, 2, 6, 0, 0);
        pulse(8'h43, 2, 6, 0, 0);
        tick(2);
        check_eq("three_level", level, 3);
        pop1(); check_eq("pop_41", rd_data, 8'h41); check_eq("pop_41_vld", rd_valid, 1); tick(1);
        pop1(); check_eq("pop_42", rd_data, 8'h42); tick(1);
        pop1(); check_eq("pop_43", rd_data, 8'h43); tick(1);
        check_eq("three_empty", level, 0);
        tick(6);

        // nine captures into eight slots
        for (int i = 0; i < 9; i++) pulse(8'(8'h10 + i), 2, 2, 0, 0);
        tick(4);
        check_eq("full_level", level, 8);
        check_eq("full_ovf", ovf, 1);
        check_eq("full_busy", busy, 1);
        pop1();
        check_eq("full_pop", rd_data, 8'h10);
        tick(2);
        check_eq("leave_full_busy", busy, 0);
        check_eq("leave_full_level", level, 7);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        check_eq("ovf_cleared", ovf, 0);

        // capture and pop land on the same edge while full
        pulse(8'h20, 2, 3, 0, 0);
        check_eq("refill_level", level, 8);
        centronix = 8'h21;
        strobe    = 1'b0;
        tick(2);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        check_eq("same_vld", rd_valid, 1);
        check_eq("same_data", rd_data, 8'h11);
        check_eq("same_level", level, 8);
        check_eq("same_ovf", ovf, 0);
        strobe = 1'b1;
        tick(4);

        // pop from an empty queue
        for (int i = 0; i < 8; i++) begin
            pop1();
            tick(1);
        end
        check_eq("drained_tail", rd_data, 8'h21);
        check_eq("drained_level", level, 0);
        pop1();
        check_eq("empty_vld", rd_valid, 0);
        check_eq("empty_level", level, 0);
        check_eq("empty_data", rd_data, 8'h21);
        tick(6);

        // reset mid-hold with strobe held active
        for (int i = 0; i < 4; i++) pulse(8'(8'h50 + i), 2, 2, 0, 0);
        centronix = 8'h5F;
        strobe    = 1'b0;
        tick(4);
        check_eq("pre_rst_level", level, 5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_eq("post_rst_level", level, 0);
        check_eq("post_rst_busy", busy, inv_busy);
        tick(6);
        check_eq("held_no_cap", level, 0);
        strobe = 1'b1;
        tick(4);
        check_eq("release_no_cap", level, 0);
        pulse(8'h66, 2, 6, 0, 0);
        check_eq("next_edge_cap", level, 1);
        drain();
        tick(6);

        // inverted strobe and busy polarity
        inv_strobe = 1'b1;
        strobe     = 1'b0;
        inv_busy   = 1'b1;
        tick(8);
        drain();
        tick(BH + 3);
        check_eq("inv_idle_busy", busy, 1);
        check_eq("inv_idle_level", level, 0);
        centronix = 8'hA5;
        strobe    = 1'b1;
        tick(4);
        check_eq("inv_hold_busy", busy, 0);
        check_eq("inv_level", level, 1);
        tick(BH);
        check_eq("inv_after_busy", busy, 1);
        strobe = 1'b0;
        tick(3);
        pop1();
        check_eq("inv_pop", rd_data, 8'hA5);
        tick(4);

        // randomized traffic with varying read pressure
        for (int r = 0; r < 3; r++) begin
            int pct;
            pct = (r == 0) ? 10 : ((r == 1) ? 45 : 80);
            for (int p = 0; p < 50; p++) begin
                if ($urandom_range(99) < 4) inv_busy = ~inv_busy;
                pulse(8'($urandom), int'($urandom_range(3, 1)), int'($urandom_range(4, 1)), pct, 4);
            end
            tick(4);
            drain();
            tick(BH + 3);
            inv_strobe = ~inv_strobe;
            strobe     = ~inv_strobe;
            tick(6);
            drain();
            tick(4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
